// File: rtl/memory_arbiter.sv
// memory_arbiter: merges icache and dcache traffic onto one RAM port.
// One RAM transaction in flight at a time; dcache has fixed priority.
// Completion and stall signals are combinational from ramstate.
// Optional build macro MEMORY_ARBITER_STARVE_GUARD_EN adds a starvation guard.
// With the guard, the icache is forced a grant after STARVE_LIMIT
// consecutive dcache grants that happened while it was waiting.
module memory_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              memerr
);

  typedef enum logic [1:0] {IDLE, DXFER, IXFER} state_t;

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;
  localparam logic [DATA_W-1:0] ERR_WORD = DATA_W'(32'hBAD1BAD1);

  state_t state_q, state_d;
  logic   memerr_q, memerr_d;
  logic   d_req, ram_done, ram_err, starve_hit;

  assign d_req    = dREN | dWEN;
  assign ram_err  = (ramstate == RAM_ERROR);
  assign ram_done = (ramstate == RAM_ACCESS) | ram_err;
  assign memerr   = memerr_q;

`ifdef MEMORY_ARBITER_STARVE_GUARD_EN
  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_q, starve_d;

  assign starve_hit = (starve_q == LIMIT);

  // Starvation counter register.
  always_ff @(posedge CLK) begin
    if (!nRST) starve_q <= '0;
    else       starve_q <= starve_d;
  end

  // Count dcache grants taken while the icache waits; clear when it is served or idle.
  always_comb begin
    starve_d = starve_q;
    if (state_q == IDLE) begin
      if (!iREN || state_d == IXFER) begin
        starve_d = '0;
      end else if (state_d == DXFER && starve_q != LIMIT) begin
        starve_d = starve_q + 1'b1;
      end
    end
  end
`else
  assign starve_hit = 1'b0;
`endif

  // State and sticky error registers.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q  <= IDLE;
      memerr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      memerr_q <= memerr_d;
    end
  end

  // Arbitration, RAM port steering and completion handshakes.
  // While nRST is low every output sits at its reset value.
  always_comb begin
    state_d  = state_q;
    memerr_d = memerr_q;
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    if (nRST) begin
      case (state_q)
        IDLE: begin
          // The guard only overrides the dcache when the icache is actually asking.
          if (d_req && !(starve_hit && iREN)) state_d = DXFER;
          else if (iREN)                      state_d = IXFER;
        end
        DXFER: begin
          ramaddr  = daddr;
          ramstore = dstore;
          if (!d_req) begin
            // Withdrawn request: drop enables now, no completion pulse.
            state_d = IDLE;
          end else begin
            ramWEN = dWEN;
            ramREN = ~dWEN;
            if (ram_done) begin
              dwait    = 1'b0;
              dload    = ram_err ? ERR_WORD : ramload;
              memerr_d = memerr_q | ram_err;
              state_d  = IDLE;
            end
          end
        end
        IXFER: begin
          ramaddr = iaddr;
          if (!iREN) begin
            state_d = IDLE;
          end else begin
            ramREN = 1'b1;
            if (ram_done) begin
              iwait    = 1'b0;
              iload    = ram_err ? ERR_WORD : ramload;
              memerr_d = memerr_q | ram_err;
              state_d  = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Sits directly downstream of the instruction/data cache pair. Merges the icache and dcache miss/fill traffic onto the single RAM port.
- Provides one outstanding RAM transaction at a time. Grants are registered. The dcache has fixed priority over the icache.
- Returns read data and a per-requester wait/ready to the cache that owns the grant.
- Tracks RAM error completions in a sticky flag.

Parameters:
- ADDR_W, 32, address width in bits
- DATA_W, 32, data word width in bits
- STARVE_LIMIT, 4, consecutive dcache grants tolerated while an icache request waits (used only with the optional feature)

Ports:
- CLK  in  1  clock
- nRST  in  1  reset, synchronous, active-low
- iREN  in  1  icache read request
- iaddr  in  ADDR_W  icache request address
- iwait  out  1  icache stall; 0 for exactly the completing cycle
- iload  out  DATA_W  icache read data; valid when iwait=0
- dREN  in  1  dcache read request
- dWEN  in  1  dcache write request
- daddr  in  ADDR_W  dcache request address
- dstore  in  DATA_W  dcache write data
- dwait  out  1  dcache stall; 0 for exactly the completing cycle
- dload  out  DATA_W  dcache read data; valid when dwait=0
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  ADDR_W  RAM address
- ramstore  out  DATA_W  RAM write data
- ramload  in  DATA_W  RAM read data
- ramstate  in  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR
- memerr  out  1  sticky error flag

Behaviour:
- Reset (nRST=0 at a CLK edge):
  - state←IDLE, starvation counter←0, memerr←0.
  - Outputs during/after reset: iwait=1, dwait=1, iload=0, dload=0, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
  - Reset mid-transfer abandons the transfer with no completion pulse.
- States: IDLE, DXFER, IXFER.
- IDLE:
  - No RAM enables are driven; both waits=1.
  - Arbitration, evaluated at the edge:
    - dREN|dWEN → DXFER.
    - Otherwise iREN → IXFER.
    - Otherwise stay in IDLE.
  - Minimum latency: request at cycle N, RAM driven at N+1.
- DXFER:
  - ramaddr=daddr, ramstore=dstore.
  - If dWEN=1: ramWEN=1, ramREN=0. dWEN wins when dREN and dWEN are both high.
  - Otherwise: ramREN=1.
  - The icache sees iwait=1.
- IXFER:
  - ramREN=1, ramaddr=iaddr, ramstore=0.
  - The dcache sees dwait=1.
- Completion:
  - Applies in DXFER/IXFER when ramstate=ACCESS.
  - Owner's wait=0 in the same cycle (combinational); owner's load=ramload.
  - Next state is IDLE. Back-to-back requests therefore cost one IDLE cycle.
- Hold while pending:
  - ramstate FREE/BUSY keeps the owner's wait=1 and holds all RAM outputs stable.
  - Requesters must also hold their address/data stable while their wait=1.
- ERROR:
  - ramstate=ERROR completes like ACCESS, but the owner's load=32'hBAD1BAD1.
  - memerr←1 at the next edge and stays 1 until reset.
- Request withdrawn mid-transfer (owner's enables both 0):
  - RAM enables drop in that same cycle.
  - Next state IDLE; no wait pulse.
- Non-owner loads read 0.
- Load outputs are combinational from ramload; there is no extra register stage.

Optional Feature:
- Macro: MEMORY_ARBITER_STARVE_GUARD_EN.
- With the macro:
  - A counter (width clog2(STARVE_LIMIT+1)) increments on each IDLE→DXFER while iREN=1.
  - The counter clears on any IDLE→IXFER and whenever iREN=0 in IDLE.
  - When the counter equals STARVE_LIMIT, the next arbitration grants IXFER even if the dcache is requesting.
  - The counter saturates at STARVE_LIMIT and resets to 0.
- Without the macro: strict dcache priority, no counter logic, and STARVE_LIMIT is ignored.

Test Plan:
- Single icache read: iREN=1, iaddr=0x40; RAM returns BUSY ×2 then ACCESS with ramload=0x8C220004 → ramREN=1, ramaddr=0x40 from cycle 1; iwait=0 and iload=0x8C220004 exactly at cycle 3; IDLE at cycle 4.
- Simultaneous requests: iREN=1 (0x40), dWEN=1 (0x100, dstore=0xDEADBEEF) in the same cycle → dcache served first (ramWEN=1, ramaddr=0x100, ramstore=0xDEADBEEF); after dwait=0, one IDLE cycle, then IXFER at 0x40; iwait stays 1 throughout the dcache transfer.
- dREN=dWEN=1, daddr=0x200 → ramWEN=1, ramREN=0.
- Error completion: ramstate=ERROR during DXFER read → dwait=0, dload=0xBAD1BAD1, memerr=1 from the next cycle, and memerr still 1 after further good transfers.
- Abort and reset:
  - dREN deasserted mid-DXFER → ramREN=0 in the same cycle, no dwait pulse, IDLE next.
  - nRST=0 during IXFER → all outputs at reset values next cycle; a later iREN is served normally.
- Starvation guard (macro on, STARVE_LIMIT=4): iREN held high with continuous dcache requests → exactly 4 DXFER grants, then one IXFER, then the counter is 0. With the macro off, the icache is never granted while the dcache requests.
